// File: rtl/pw_conv_pkg.sv
// pw_conv_pkg: shared state type and sizing/rescale helpers
// for the pointwise convolution engine.
package pw_conv_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } pw_state_t;

  localparam int SAT_W = 64;

  function automatic int cw(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int acc_w(input int width, input int chin);
    return 2 * width + $clog2(chin);
  endfunction

  function automatic int ngrp(input int chout, input int dsp);
    return chout / dsp;
  endfunction

  // Floor rescale of acc+bias, clamp to WIDTH, optional ReLU.
  function automatic logic signed [SAT_W-1:0] sat_shift(
    input logic signed [SAT_W-1:0] acc,
    input logic signed [SAT_W-1:0] bias,
    input int                      frac,
    input int                      width,
    input bit                      relu
  );
    logic signed [SAT_W-1:0] s;
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    s  = (acc + bias) >>> frac;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (s > hi) begin
      s = hi;
    end else if (s < lo) begin
      s = lo;
    end
    if (relu && (s < 0)) begin
      s = '0;
    end
    return s;
  endfunction

endpackage

// File: rtl/pw_conv_engine_lane.sv
// pw_mac_lane: one MAC lane with operand registers,
// a registered product and a load/accumulate register.
module pw_mac_lane
  import pw_conv_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int ACC_W = 41
)(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_take,
  input  logic signed [WIDTH-1:0] i_pix,
  input  logic signed [WIDTH-1:0] i_ker,
  input  logic                    i_pv,
  input  logic                    i_av,
  input  logic                    i_load,
  output logic signed [ACC_W-1:0] o_acc
);

  localparam int PW = 2 * WIDTH;

  logic signed [WIDTH-1:0] r_pix;
  logic signed [WIDTH-1:0] r_ker;
  logic signed [PW-1:0]    r_prod;
  logic signed [ACC_W-1:0] r_acc;
  logic signed [PW-1:0]    w_a;
  logic signed [PW-1:0]    w_b;
  logic signed [ACC_W-1:0] w_ext;

  assign w_a   = PW'(r_pix);
  assign w_b   = PW'(r_ker);
  assign w_ext = ACC_W'(r_prod);
  assign o_acc = r_acc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pix  <= '0;
      r_ker  <= '0;
      r_prod <= '0;
      r_acc  <= '0;
    end else begin
      if (i_take) begin
        r_pix <= i_pix;
        r_ker <= i_ker;
      end
      if (i_pv) begin
        r_prod <= w_a * w_b;
      end
      // channel 0 reloads, so groups chain with no clear bubble
      if (i_av) begin
        r_acc <= i_load ? w_ext : r_acc + w_ext;
      end
    end
  end

endmodule

// File: rtl/pw_conv_engine.sv
// pw_conv_engine: 1x1 convolution layer engine, DSP_NO MAC lanes,
// output tiling over CHOUT/DSP_NO groups, rescale and saturation.
module pw_conv_engine
  import pw_conv_pkg::*;
#(
  parameter  int WIDTH  = 16,
  parameter  int FRAC   = 14,
  parameter  int DSP_NO = 64,
  parameter  int CHIN   = 512,
  parameter  int CHOUT  = 64,
  parameter  int WOUT   = 16,
  parameter  int RELU   = 1,
  localparam int NGRP   = ngrp(CHOUT, DSP_NO),
  localparam int NPIX   = WOUT * WOUT,
  localparam int ACC_W  = acc_w(WIDTH, CHIN),
  localparam int PIX_W  = cw(NPIX),
  localparam int CH_W   = cw(CHIN),
  localparam int GRP_W  = $clog2(NGRP) + 1,
  localparam int AW     = cw(CHIN * NGRP)
)(
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        ifm_valid,
  input  logic [WIDTH-1:0]            ifm,
  output logic                        ifm_ready,
  output logic [PIX_W-1:0]            pix_idx,
  output logic [CH_W-1:0]             ch_idx,
  output logic [GRP_W-1:0]            grp_idx,
  output logic [AW-1:0]               w_addr,
  input  logic [DSP_NO*WIDTH-1:0]     w_data,
  input  logic [DSP_NO*2*WIDTH-1:0]   bias,
  output logic [DSP_NO*WIDTH-1:0]     ofm,
  output logic                        ofm_valid,
  output logic [GRP_W-1:0]            ofm_grp,
  output logic                        busy,
  output logic                        done
);

  localparam int BW = 2 * WIDTH;

  pw_state_t r_state;
  pw_state_t w_nxt;

  logic [PIX_W-1:0] r_pix;
  logic [CH_W-1:0]  r_ch;
  logic [GRP_W-1:0] r_grp;

  logic w_take;
  logic w_start;
  logic w_last_ch;
  logic w_last_grp;
  logic w_last_pix;
  logic w_fin_beat;

  logic             r_v0, r_f0, r_l0, r_fin0;
  logic [GRP_W-1:0] r_g0;
  logic             r_v1, r_f1, r_l1, r_fin1;
  logic [GRP_W-1:0] r_g1;
  logic             r_v2, r_fin2;
  logic [GRP_W-1:0] r_g2;
  logic             r_ofm_fin;

  logic signed [ACC_W-1:0] w_acc [DSP_NO];
  logic [DSP_NO*WIDTH-1:0] w_sat;

  assign pix_idx = r_pix;
  assign ch_idx  = r_ch;
  assign grp_idx = r_grp;
  assign w_addr  = AW'(int'(r_grp) * CHIN + int'(r_ch));

  assign w_start    = start && (r_state == S_IDLE);
  assign w_take     = ifm_valid && (r_state == S_RUN);
  assign w_last_ch  = (r_ch == CH_W'(CHIN - 1));
  assign w_last_grp = (r_grp == GRP_W'(NGRP - 1));
  assign w_last_pix = (r_pix == PIX_W'(NPIX - 1));
  assign w_fin_beat = w_take && w_last_ch
                   && w_last_grp && w_last_pix;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nxt;
    end
  end

  always_comb begin
    w_nxt     = r_state;
    ifm_ready = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (start) w_nxt = S_RUN;
      end
      S_RUN: begin
        ifm_ready = 1'b1;
        busy      = 1'b1;
        if (w_fin_beat) w_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        busy = 1'b1;
        if (ofm_valid && r_ofm_fin) w_nxt = S_DONE;
      end
      S_DONE: begin
        done  = 1'b1;
        w_nxt = S_IDLE;
      end
      default: w_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pix <= '0;
      r_ch  <= '0;
      r_grp <= '0;
    end else if (w_start) begin
      r_pix <= '0;
      r_ch  <= '0;
      r_grp <= '0;
    end else if (w_take) begin
      if (w_last_ch) begin
        r_ch <= '0;
        if (w_last_grp) begin
          r_grp <= '0;
          r_pix <= w_last_pix ? '0 : r_pix + 1'b1;
        end else begin
          r_grp <= r_grp + 1'b1;
        end
      end else begin
        r_ch <= r_ch + 1'b1;
      end
    end
  end

  // Tags travel alongside operands, product and accumulator.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v0 <= 1'b0; r_f0 <= 1'b0; r_l0 <= 1'b0;
      r_fin0 <= 1'b0; r_g0 <= '0;
      r_v1 <= 1'b0; r_f1 <= 1'b0; r_l1 <= 1'b0;
      r_fin1 <= 1'b0; r_g1 <= '0;
      r_v2 <= 1'b0; r_fin2 <= 1'b0; r_g2 <= '0;
    end else begin
      r_v0   <= w_take;
      r_f0   <= (r_ch == '0);
      r_l0   <= w_last_ch;
      r_fin0 <= w_fin_beat;
      r_g0   <= r_grp;
      r_v1   <= r_v0;
      r_f1   <= r_f0;
      r_l1   <= r_l0;
      r_fin1 <= r_fin0;
      r_g1   <= r_g0;
      r_v2   <= r_v1 && r_l1;
      r_fin2 <= r_fin1;
      r_g2   <= r_g1;
    end
  end

  for (genvar g = 0; g < DSP_NO; g++) begin : g_lane
    pw_mac_lane #(
      .WIDTH (WIDTH),
      .ACC_W (ACC_W)
    ) u_lane (
      .clk    (clk),
      .rst    (rst),
      .i_take (w_take),
      .i_pix  (ifm),
      .i_ker  (w_data[g*WIDTH +: WIDTH]),
      .i_pv   (r_v0),
      .i_av   (r_v1),
      .i_load (r_f1),
      .o_acc  (w_acc[g])
    );
  end

  always_comb begin
    w_sat = '0;
    for (int i = 0; i < DSP_NO; i++) begin
      w_sat[i*WIDTH +: WIDTH] = WIDTH'(sat_shift(
        SAT_W'(w_acc[i]),
        SAT_W'($signed(bias[i*BW +: BW])),
        FRAC, WIDTH, (RELU != 0)));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ofm       <= '0;
      ofm_valid <= 1'b0;
      ofm_grp   <= '0;
      r_ofm_fin <= 1'b0;
    end else begin
      ofm_valid <= r_v2;
      if (r_v2) begin
        ofm       <= w_sat;
        ofm_grp   <= r_g2;
        r_ofm_fin <= r_fin2;
      end
    end
  end

endmodule

// File: tb/tb_pw_conv_engine.sv
// tb_pw_conv_engine: randomized self-checking bench with a
// behavioural reference model of the pointwise layer.
module tb_pw_conv_engine;

  localparam int CHIN = 4;
  localparam int NGRP = 2;
  localparam int NPIX = 4;
  localparam int NSTR = NPIX * NGRP;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          start_a = 1'b0;
  logic          vld_a = 1'b0;
  logic [15:0]   ifm_a;
  logic          rdy_a;
  logic [1:0]    pix_a;
  logic [1:0]    ch_a;
  logic [1:0]    grp_a;
  logic [2:0]    waddr_a;
  logic [63:0]   wdata_a;
  logic [127:0]  bias_a;
  logic [63:0]   ofm_a;
  logic          ofmv_a;
  logic [1:0]    ofmg_a;
  logic          busy_a;
  logic          done_a;

  logic          start_b = 1'b0;
  logic          vld_b = 1'b0;
  logic [15:0]   ifm_b;
  logic          rdy_b;
  logic [0:0]    pix_b;
  logic [1:0]    ch_b;
  logic [0:0]    grp_b;
  logic [1:0]    waddr_b;
  logic [63:0]   wdata_b;
  logic [127:0]  bias_b;
  logic [63:0]   ofm_b;
  logic          ofmv_b;
  logic [0:0]    ofmg_b;
  logic          busy_b;
  logic          done_b;

  logic signed [15:0] act_m [NPIX][CHIN];
  logic signed [15:0] w_m   [NGRP*CHIN][4];
  logic signed [31:0] b_m   [NGRP][4];

  int cmp_n = 0;
  int err_n = 0;
  int cyc = 0;
  int bcnt = 0;
  bit done_seen = 0;
  int done_cyc = 0;
  bit done_busy = 0;
  bit done_b_seen = 0;
  logic [63:0] q_ofm[$];
  logic [1:0]  q_grp[$];
  int          q_cyc[$];
  int          q_lb[$];
  logic [63:0] qb_ofm[$];
  logic [63:0] q_save[$];

  pw_conv_engine #(
    .WIDTH(16), .FRAC(14), .DSP_NO(4), .CHIN(CHIN),
    .CHOUT(8), .WOUT(2), .RELU(0)
  ) dut (
    .clk(clk), .rst(rst), .start(start_a),
    .ifm_valid(vld_a), .ifm(ifm_a), .ifm_ready(rdy_a),
    .pix_idx(pix_a), .ch_idx(ch_a), .grp_idx(grp_a),
    .w_addr(waddr_a), .w_data(wdata_a), .bias(bias_a),
    .ofm(ofm_a), .ofm_valid(ofmv_a), .ofm_grp(ofmg_a),
    .busy(busy_a), .done(done_a)
  );

  pw_conv_engine #(
    .WIDTH(16), .FRAC(14), .DSP_NO(4), .CHIN(CHIN),
    .CHOUT(4), .WOUT(1), .RELU(1)
  ) dut_r (
    .clk(clk), .rst(rst), .start(start_b),
    .ifm_valid(vld_b), .ifm(ifm_b), .ifm_ready(rdy_b),
    .pix_idx(pix_b), .ch_idx(ch_b), .grp_idx(grp_b),
    .w_addr(waddr_b), .w_data(wdata_b), .bias(bias_b),
    .ofm(ofm_b), .ofm_valid(ofmv_b), .ofm_grp(ofmg_b),
    .busy(busy_b), .done(done_b)
  );

  // Upstream RAM / weight ROM / bias source
  assign ifm_a = act_m[pix_a][ch_a];
  assign ifm_b = act_m[0][ch_b];

  always_comb begin
    wdata_a = '0;
    wdata_b = '0;
    bias_a  = '0;
    bias_b  = '0;
    for (int l = 0; l < 4; l++) begin
      wdata_a[l*16 +: 16] = w_m[waddr_a][l];
      wdata_b[l*16 +: 16] = w_m[waddr_b][l];
      bias_a[l*32 +: 32]  = b_m[bcnt % NGRP][l];
      bias_b[l*32 +: 32]  = b_m[0][l];
    end
  end

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (vld_a && rdy_a && (ch_a == 2'(CHIN - 1)))
      q_lb.push_back(cyc);
    if (ofmv_a) begin
      q_ofm.push_back(ofm_a);
      q_grp.push_back(ofmg_a);
      q_cyc.push_back(cyc);
      bcnt = bcnt + 1;
    end
    if (done_a) begin
      done_seen = 1;
      done_cyc  = cyc;
      done_busy = busy_a;
    end
    if (ofmv_b) qb_ofm.push_back(ofm_b);
    if (done_b) done_b_seen = 1;
  end

  function automatic logic [63:0] model(input int p, input int g,
                                        input bit relu);
    logic [63:0] v;
    longint s;
    longint q;
    v = '0;
    for (int l = 0; l < 4; l++) begin
      s = longint'(b_m[g][l]);
      for (int c = 0; c < CHIN; c++)
        s += longint'(act_m[p][c]) * longint'(w_m[g*CHIN+c][l]);
      q = s / 16384;
      if ((s % 16384 != 0) && (s < 0)) q = q - 1;
      if (q > 32767) q = 32767;
      if (q < -32768) q = -32768;
      if (relu && q < 0) q = 0;
      v[l*16 +: 16] = q[15:0];
    end
    return v;
  endfunction

  function automatic logic signed [15:0] rnd16();
    logic signed [15:0] x;
    x = 16'($urandom);
    return x >>> $urandom_range(0, 4);
  endfunction

  task automatic fill_random();
    for (int p = 0; p < NPIX; p++)
      for (int c = 0; c < CHIN; c++) act_m[p][c] = rnd16();
    for (int a = 0; a < NGRP*CHIN; a++)
      for (int l = 0; l < 4; l++) w_m[a][l] = rnd16();
    for (int g = 0; g < NGRP; g++)
      for (int l = 0; l < 4; l++)
        b_m[g][l] = 32'($urandom) >>> $urandom_range(2, 8);
  endtask

  task automatic clear_q();
    q_ofm.delete(); q_grp.delete(); q_cyc.delete();
    q_lb.delete(); qb_ofm.delete();
    bcnt = 0;
    done_seen = 0;
    done_b_seen = 0;
  endtask

  task automatic run_a(input int gap, input bit restart);
    clear_q();
    @(posedge clk); #1;
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    for (int n = 0; n < 400 && !done_seen; n++) begin
      vld_a   = ($urandom_range(0, 99) >= gap);
      start_a = restart && (n == 10);
      @(posedge clk); #1;
    end
    vld_a   = 1'b0;
    start_a = 1'b0;
    cmp_n++;
    if (!done_seen) begin
      err_n++;
      $display("FAIL done_timeout: got no done, expected done");
    end
  endtask

  task automatic check_model(input string nm);
    cmp_n++;
    if (q_ofm.size() !== NSTR) begin
      err_n++;
      $display("FAIL %s_count: got %0d strobes, expected %0d",
               nm, q_ofm.size(), NSTR);
    end
    for (int k = 0; k < NSTR && k < q_ofm.size(); k++) begin
      logic [63:0] e;
      e = model(k / NGRP, k % NGRP, 1'b0);
      cmp_n++;
      if (q_ofm[k] !== e) begin
        err_n++;
        $display("FAIL %s_ofm[%0d]: got %h, expected %h",
                 nm, k, q_ofm[k], e);
      end
      cmp_n++;
      if (q_grp[k] !== 2'(k % NGRP)) begin
        err_n++;
        $display("FAIL %s_grp[%0d]: got %0d, expected %0d",
                 nm, k, q_grp[k], k % NGRP);
      end
    end
  endtask

  task automatic check_idle(input string nm);
    cmp_n++;
    if ({ofmv_a, busy_a, done_a, rdy_a} !== 4'b0) begin
      err_n++;
      $display("FAIL %s_ctl: got v/b/d/r=%b, expected 0000", nm,
               {ofmv_a, busy_a, done_a, rdy_a});
    end
    cmp_n++;
    if ({pix_a, ch_a, grp_a} !== 6'b0) begin
      err_n++;
      $display("FAIL %s_idx: got %b, expected 0", nm,
               {pix_a, ch_a, grp_a});
    end
    cmp_n++;
    if (ofm_a !== 64'h0) begin
      err_n++;
      $display("FAIL %s_ofm: got %h, expected 0", nm, ofm_a);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_idle("reset");
    start_a = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    start_a = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    cmp_n++;
    if (busy_a !== 1'b0) begin
      err_n++;
      $display("FAIL start_in_rst: got busy %b, expected 0", busy_a);
    end
  endtask

  task automatic test_basic();
    logic [63:0] e;
    e = {16'h7FFF, 16'h0000, 16'hC000, 16'h7FFF};
    for (int p = 0; p < NPIX; p++)
      for (int c = 0; c < CHIN; c++) act_m[p][c] = 16'sh4000;
    for (int a = 0; a < NGRP*CHIN; a++) begin
      w_m[a][0] = 16'sh2000;
      w_m[a][1] = -16'sh1000;
      w_m[a][2] = 16'sh0000;
      w_m[a][3] = 16'sh4000;
    end
    for (int g = 0; g < NGRP; g++)
      for (int l = 0; l < 4; l++) b_m[g][l] = 32'sh0;
    run_a(0, 1'b0);
    cmp_n++;
    if (q_ofm.size() !== NSTR) begin
      err_n++;
      $display("FAIL basic_count: got %0d, expected %0d",
               q_ofm.size(), NSTR);
    end
    for (int k = 0; k < q_ofm.size(); k++) begin
      cmp_n++;
      if (q_ofm[k] !== e) begin
        err_n++;
        $display("FAIL basic_ofm[%0d]: got %h, expected %h",
                 k, q_ofm[k], e);
      end
      cmp_n++;
      if (q_grp[k] !== 2'(k % NGRP)) begin
        err_n++;
        $display("FAIL basic_grp[%0d]: got %0d, expected %0d",
                 k, q_grp[k], k % NGRP);
      end
      if (k < q_lb.size()) begin
        cmp_n++;
        if (q_cyc[k] - q_lb[k] !== 4) begin
          err_n++;
          $display("FAIL basic_latency[%0d]: got %0d, expected 4",
                   k, q_cyc[k] - q_lb[k]);
        end
      end
      if (k > 0) begin
        cmp_n++;
        if (q_cyc[k] - q_cyc[k-1] !== CHIN) begin
          err_n++;
          $display("FAIL basic_bubble[%0d]: got gap %0d, expected %0d",
                   k, q_cyc[k] - q_cyc[k-1], CHIN);
        end
      end
    end
    if (q_cyc.size() > 0) begin
      cmp_n++;
      if (done_cyc - q_cyc[q_cyc.size()-1] !== 1) begin
        err_n++;
        $display("FAIL basic_done_delay: got %0d, expected 1",
                 done_cyc - q_cyc[q_cyc.size()-1]);
      end
    end
    cmp_n++;
    if (done_busy !== 1'b0) begin
      err_n++;
      $display("FAIL basic_busy_at_done: got %b, expected 0",
               done_busy);
    end
  endtask

  task automatic test_relu();
    logic [63:0] e;
    e = {16'h7FFF, 16'h0000, 16'h0000, 16'h7FFF};
    clear_q();
    @(posedge clk); #1;
    start_b = 1'b1;
    @(posedge clk); #1;
    start_b = 1'b0;
    vld_b = 1'b1;
    for (int n = 0; n < 100 && !done_b_seen; n++) begin
      @(posedge clk); #1;
    end
    vld_b = 1'b0;
    cmp_n++;
    if (qb_ofm.size() !== 1) begin
      err_n++;
      $display("FAIL relu_count: got %0d, expected 1", qb_ofm.size());
    end
    if (qb_ofm.size() > 0) begin
      cmp_n++;
      if (qb_ofm[0] !== e) begin
        err_n++;
        $display("FAIL relu_ofm: got %h, expected %h", qb_ofm[0], e);
      end
    end
  endtask

  task automatic test_bias_neg();
    fill_random();
    for (int p = 0; p < NPIX; p++)
      for (int c = 0; c < CHIN; c++) act_m[p][c] = 16'sh0;
    for (int g = 0; g < NGRP; g++)
      for (int l = 0; l < 4; l++) b_m[g][l] = -(32'sd1 <<< 27);
    run_a(0, 1'b0);
    cmp_n++;
    if (q_ofm.size() !== NSTR) begin
      err_n++;
      $display("FAIL bias_count: got %0d, expected %0d",
               q_ofm.size(), NSTR);
    end
    for (int k = 0; k < q_ofm.size(); k++) begin
      cmp_n++;
      if (q_ofm[k] !== {4{16'hE000}}) begin
        err_n++;
        $display("FAIL bias_ofm[%0d]: got %h, expected %h",
                 k, q_ofm[k], {4{16'hE000}});
      end
    end
  endtask

  task automatic test_random_gaps();
    for (int it = 0; it < 3; it++) begin
      fill_random();
      run_a(0, 1'b0);
      check_model("rand_full");
      q_save = q_ofm;
      run_a(50, 1'b0);
      check_model("rand_gap");
      for (int k = 0; k < q_save.size() && k < q_ofm.size(); k++) begin
        cmp_n++;
        if (q_ofm[k] !== q_save[k]) begin
          err_n++;
          $display("FAIL gap_vs_full[%0d]: got %h, expected %h",
                   k, q_ofm[k], q_save[k]);
        end
      end
    end
  endtask

  task automatic test_rst_mid();
    fill_random();
    clear_q();
    @(posedge clk); #1;
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    vld_a = 1'b1;
    for (int n = 0; n < 50 && grp_a != 2'd1; n++) begin
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check_idle("rst_mid");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    clear_q();
    repeat (10) @(posedge clk);
    #1;
    vld_a = 1'b0;
    cmp_n++;
    if (q_ofm.size() !== 0 || busy_a !== 1'b0) begin
      err_n++;
      $display("FAIL rst_partial: got %0d strobes busy %b, expected 0 0",
               q_ofm.size(), busy_a);
    end
    run_a(0, 1'b1);
    check_model("after_rst");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_relu();
    test_bias_neg();
    test_random_gaps();
    test_rst_mid();
    repeat (5) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             cmp_n, err_n);
    $finish;
  end

endmodule

// File: doc/pw_conv_engine.md
# pw_conv_engine

Parametrised 1x1 (pointwise) convolution layer engine, the generalised successor of the per-layer fire squeeze blocks. Streams one signed fixed-point input activation per cycle, multiplies by `DSP_NO` parallel weights from a weight ROM, accumulates over `CHIN` channels, and adds bias, rescale, saturation and optional ReLU. Tiles `CHOUT` outputs over `CHOUT/DSP_NO` groups and counts pixels to end-of-layer. It sits between the feature-map RAM reader and the output RAM writer.

## Interface
- `WIDTH`, 16: activation, weight and output width (signed two's complement).
- `FRAC`, 14: fractional bits of activations and weights; products carry 2*FRAC.
- `DSP_NO`, 64: parallel MAC lanes, which is also the output group size.
- `CHIN`, 512: input channels per pixel, ≥2.
- `CHOUT`, 64: output channels; must be a multiple of `DSP_NO`.
- `WOUT`, 16: output spatial dim; the layer covers WOUT*WOUT pixels.
- `RELU`, 1: 1 clamps negative results to 0; 0 gives signed saturated output.
- `clk` in 1: single clock.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: one-cycle pulse; begins the layer from IDLE and is ignored otherwise.
- `ifm_valid` in 1: input beat valid.
- `ifm` in WIDTH: activation for (pixel, channel) = (`pix_idx`, `ch_idx`).
- `ifm_ready` out 1: engine accepts a beat; a beat is taken when `ifm_valid && ifm_ready`.
- `pix_idx` out clog2(WOUT*WOUT): pixel the engine expects next.
- `ch_idx` out clog2(CHIN): channel the engine expects next.
- `grp_idx` out clog2(CHOUT/DSP_NO)+1: output group in progress.
- `w_addr` out clog2(CHIN*CHOUT/DSP_NO): weight ROM address = `grp_idx`*CHIN + `ch_idx`.
- `w_data` in DSP_NO x WIDTH: combinational ROM read of `w_addr`.
- `bias` in DSP_NO x 2*WIDTH: bias for the current group, in Q(2*FRAC).
- `ofm` out DSP_NO x WIDTH: result lanes.
- `ofm_valid` out 1: one-cycle strobe.
- `ofm_grp` out clog2(CHOUT/DSP_NO)+1: group of the current `ofm`.
- `busy` out 1: high from accepted `start` to `done`.
- `done` out 1: one-cycle pulse after the last `ofm_valid`.

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE -> RUN on `start`; all index counters are zero.
  - RUN: `ifm_ready`=1. Each accepted beat increments `ch_idx`. At CHIN-1 it wraps to 0 and `grp_idx` increments. At the last group it wraps to 0 and `pix_idx` increments. The accepted beat with index (WOUT²-1, last group, CHIN-1) moves the FSM to DRAIN.
  - DRAIN: `ifm_ready`=0 until the final `ofm_valid`, then -> DONE.
  - DONE: `done`=1 for one cycle, then -> IDLE.
- Upstream replays the same CHIN activations once per group for each pixel, addressed by the index outputs.
- Datapath per lane:
  - Register pix and kernel.
  - Register the WIDTH×WIDTH signed product.
  - Accumulator is ACC_W = 2*WIDTH+clog2(CHIN) bits. On channel 0 of a group it loads the product; otherwise it adds the product. There is no clear bubble between groups.
- Output: r = (acc + sign-extended bias) >>> FRAC (arithmetic shift, truncation toward −inf). Saturate r to [−2^(WIDTH−1), 2^(WIDTH−1)−1]. If `RELU`, negative results become 0.
- `bias` must be held stable for the group until its `ofm_valid`.
- There is no output backpressure. The consumer must take `ofm` on `ofm_valid`. `ofm` holds its value until the next strobe.
- Reset or mid-layer `rst`: state returns to IDLE and all counters, accumulators, pipeline valids, `ofm`, `ofm_valid`, `busy` and `done` go to 0. No partial `ofm_valid` is produced after reset.

## Timing
- Beat accepted at edge t: kernel and pix are registered at t, the product at t+1, and the accumulator updates at t+2.
- `ofm_valid` is high during the cycle after edge t+3, where t is the edge accepting channel CHIN-1. Latency is 4 cycles from the last beat to the strobe.
- `ifm_valid` gaps stall the pipeline front only. In-flight beats still complete.
- Back-to-back groups sustain 1 beat/cycle with no idle cycles. Throughput is WOUT²·(CHOUT/DSP_NO)·CHIN cycles per layer.
- `done` asserts on the cycle after the final `ofm_valid`. `busy` drops with `done`.
- `start` during `busy` is ignored. `start` in the same cycle as `rst` is ignored.

## Structure
- Package `pw_conv_pkg`:
  - state enum `pw_state_t`;
  - function `sat_shift(acc, bias, FRAC, WIDTH, RELU)`;
  - localparam helpers for ACC_W, NGRP and address widths.
- Sub-module `pw_mac_lane`: one lane (pix/ker registers, multiplier, load/accumulate). Instantiated DSP_NO times via generate.
- The top level holds the FSM, index counters, pipeline valid/first/last tags and the output stage.

## Test plan
- DSP_NO=4, CHIN=4, CHOUT=4, WOUT=1, RELU=0, FRAC=14. ifm = 1.0 (0x4000) on all channels; weights 0.5 on lane 0, −0.25 on lane 1, 0 on lane 2, 1.0 on lane 3; bias 0 -> one `ofm_valid` with {0x8000 saturate? no: 2.0 -> 0x7FFF, −1.0 -> 0xC000, 0x0000, 4.0 -> 0x7FFF}, then `done` 1 cycle later. Check `ofm_valid` is exactly 4 cycles after the last beat.
- Same setup with RELU=1 -> lane 1 outputs 0x0000.
- CHOUT=8 (2 groups), WOUT=2 -> 8 strobes, `ofm_grp` alternating 0,1, no bubble between groups with continuous `ifm_valid`.
- Random `ifm_valid` gaps (50%) -> results bit-identical to the gap-free run.
- Bias = −0.5 in Q28, activations 0, RELU=0 -> every lane outputs 0xE000.
- `rst` asserted mid-group 1 -> all outputs 0 immediately. A following `start` reproduces the full correct layer. `start` during `busy` changes nothing.
